// File: rtl/rr_arbiter_4_n.sv
// Four-way round-robin arbiter with active-low requests, enable and one-hot-low grants.
// Grants are registered, hold time is bounded under contention, and owners never hand over directly.
module rr_arbiter_4_n #(
   parameter int unsigned MAX_HOLD = 8,
   parameter int unsigned CNT_W    = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable_n,
   input  logic [3:0] req_n,
   output logic [3:0] gnt_n,
   output logic [1:0] gnt_idx,
   output logic       busy
);

   typedef enum logic [0:0] {StIdle, StGrant} state_e;

   localparam logic [CNT_W-1:0] HoldMax = CNT_W'(MAX_HOLD);

   if ((MAX_HOLD < 1) || (MAX_HOLD > 255) || ((64'd1 << CNT_W) <= 64'(MAX_HOLD))) begin : g_bad_param
      $error("rr_arbiter_4_n: MAX_HOLD must be 1..255 and fit in CNT_W bits");
   end

   state_e           r_state;
   logic [1:0]       r_owner;
   logic [1:0]       r_last;
   logic [CNT_W-1:0] r_hold_cnt;
   logic [3:0]       r_gnt_n;
   logic [1:0]       r_gnt_idx;
   logic             r_busy;

   logic [3:0]       w_req;
   logic [3:0]       w_owner_mask;
   logic [3:0]       w_others;
   logic             w_pick_valid;
   logic [1:0]       w_pick;
   logic [1:0]       w_cand;
   logic             w_hold_full;
   logic             w_release;

   assign w_req        = ~req_n;
   assign w_owner_mask = 4'b0001 << r_owner;
   assign w_others     = w_req & ~w_owner_mask;
   assign w_hold_full  = (r_hold_cnt == HoldMax);

   // Release wins over everything else; preemption only once the hold budget is used up.
   assign w_release = req_n[r_owner] | enable_n | (w_hold_full & (|w_others));

   // Walk last+4 down to last+1 so the candidate nearest after last is the one kept.
   always_comb begin
      w_pick_valid = 1'b0;
      w_pick       = 2'd0;
      w_cand       = 2'd0;
      for (int k = 4; k >= 1; k--) begin
         w_cand = r_last + 2'(k);
         if (w_req[w_cand]) begin
            w_pick       = w_cand;
            w_pick_valid = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= StIdle;
         r_owner    <= 2'd0;
         r_last     <= 2'd3;
         r_hold_cnt <= '0;
         r_gnt_n    <= 4'b1111;
         r_gnt_idx  <= 2'd0;
         r_busy     <= 1'b0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (!enable_n && w_pick_valid) begin
                  r_state    <= StGrant;
                  r_owner    <= w_pick;
                  r_hold_cnt <= CNT_W'(1);
                  r_gnt_n    <= ~(4'b0001 << w_pick);
                  r_gnt_idx  <= w_pick;
                  r_busy     <= 1'b1;
               end
            end
            StGrant: begin
               if (w_release) begin
                  r_state    <= StIdle;
                  r_last     <= r_owner;
                  r_hold_cnt <= '0;
                  r_gnt_n    <= 4'b1111;
                  r_gnt_idx  <= 2'd0;
                  r_busy     <= 1'b0;
               end else if (!w_hold_full) begin
                  r_hold_cnt <= r_hold_cnt + CNT_W'(1);
               end
            end
            default: begin
               r_state <= StIdle;
               r_gnt_n <= 4'b1111;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign gnt_n   = r_gnt_n;
   assign gnt_idx = r_gnt_idx;
   assign busy    = r_busy;

   a_one_hot_low: assert property (@(posedge clk) disable iff (reset)
      $countones(~r_gnt_n) <= 1);
   a_idx_match: assert property (@(posedge clk) disable iff (reset)
      r_busy |-> (r_gnt_n[r_gnt_idx] == 1'b0));
   a_busy_match: assert property (@(posedge clk) disable iff (reset)
      r_busy == (r_gnt_n != 4'b1111));

endmodule

// File: tb/tb_rr_arbiter_4_n.sv
// Bench for rr_arbiter_4_n: directed literal checks plus randomized traffic against a
// behavioural round-robin model with invariant and starvation checks.
module tb_rr_arbiter_4_n;

   localparam int MAX_HOLD   = 8;
   localparam int CNT_W      = 8;
   localparam int WAIT_BOUND = 4 * (MAX_HOLD + 1);

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable_n = 1'b1;
   logic [3:0] req_n = 4'hf;
   logic [3:0] gnt_n;
   logic [1:0] gnt_idx;
   logic       busy;

   int errors = 0;
   int checks = 0;
   bit chk_on = 1'b0;

   always #5 clk = ~clk;

   rr_arbiter_4_n #(
      .MAX_HOLD(MAX_HOLD),
      .CNT_W   (CNT_W)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .enable_n(enable_n),
      .req_n   (req_n),
      .gnt_n   (gnt_n),
      .gnt_idx (gnt_idx),
      .busy    (busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: owner -1 means idle, held counts granted cycles of the current owner.
   int m_owner = -1;
   int m_last  = 3;
   int m_held  = 0;

   always @(posedge clk) begin : model
      int  n_owner;
      int  n_last;
      int  n_held;
      int  c;
      bit  other;
      n_owner = m_owner;
      n_last  = m_last;
      n_held  = m_held;
      other   = 1'b0;
      if (reset) begin
         n_owner = -1;
         n_last  = 3;
         n_held  = 0;
      end else if (m_owner < 0) begin
         if (!enable_n) begin
            for (int k = 1; k <= 4; k++) begin
               c = (m_last + k) % 4;
               if (n_owner < 0 && req_n[c] == 1'b0) begin
                  n_owner = c;
                  n_held  = 1;
               end
            end
         end
      end else begin
         for (int j = 0; j < 4; j++)
            if (j != m_owner && req_n[j] == 1'b0) other = 1'b1;
         if (req_n[m_owner] || enable_n || (m_held >= MAX_HOLD && other)) begin
            n_last  = m_owner;
            n_owner = -1;
            n_held  = 0;
         end else begin
            n_held = m_held + 1;
         end
      end
      m_owner <= n_owner;
      m_last  <= n_last;
      m_held  <= n_held;
   end

   // Compare process: runs every cycle, after both model and DUT have settled.
   logic [3:0] prev_gnt = 4'hf;
   bit         prev_busy = 1'b0;
   int         waitc[4];

   always @(posedge clk) begin : compare
      logic [3:0] exp_g;
      #2;
      if (chk_on) begin
         exp_g = (m_owner < 0) ? 4'hf : ~(4'b0001 << m_owner);
         chk("gnt_n", gnt_n, exp_g);
         chk("gnt_idx", gnt_idx, (m_owner < 0) ? 0 : m_owner);
         chk("busy", busy, (m_owner >= 0));
         chk("one_hot_low", ($countones(~gnt_n) <= 1), 1);
         if (busy) chk("idx_vs_gnt", gnt_n[gnt_idx], 1'b0);
         if (prev_busy && busy) chk("no_direct_handover", gnt_n, prev_gnt);
         for (int i = 0; i < 4; i++) begin
            if (reset || req_n[i] || !gnt_n[i]) waitc[i] = 0;
            else if (!enable_n) waitc[i] = waitc[i] + 1;
            chk("starvation_bound", (waitc[i] <= WAIT_BOUND), 1);
         end
         prev_gnt  = gnt_n;
         prev_busy = busy;
      end
   end

   task automatic drive(input logic [3:0] r, input logic e, input logic rs);
      @(negedge clk);
      req_n    = r;
      enable_n = e;
      reset    = rs;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      drive(4'hf, 1'b1, 1'b1);
      tick();
   endtask

   initial begin
      logic [3:0] r;
      logic       e;
      logic       rs;
      logic [3:0] exp_g;
      int         o;
      for (int i = 0; i < 4; i++) waitc[i] = 0;

      // Reset holds grants off even with every request active.
      tick();
      chk_on = 1'b1;
      for (int n = 0; n < 2; n++) begin
         drive(4'b0000, 1'b0, 1'b1);
         tick();
         chk("reset_gnt_n", gnt_n, 4'b1111);
         chk("reset_busy", busy, 1'b0);
      end
      drive(4'b0000, 1'b0, 1'b0);
      tick();
      chk("post_reset_gnt_n", gnt_n, 4'b1110);
      chk("post_reset_idx", gnt_idx, 2'd0);

      // Single requester holds indefinitely without competition.
      reset_dut();
      for (int n = 0; n < 5; n++) begin
         drive(4'b1011, 1'b0, 1'b0);
         tick();
         chk("single_gnt_n", gnt_n, 4'b1011);
      end
      drive(4'b1111, 1'b0, 1'b0);
      tick();
      chk("single_release", gnt_n, 4'b1111);

      // Full contention: 8 granted cycles then 1 idle, owners 0,1,2,3,0.
      reset_dut();
      for (int t = 1; t <= 44; t++) begin
         drive(4'b0000, 1'b0, 1'b0);
         tick();
         o     = ((t - 1) / 9) % 4;
         exp_g = ((t - 1) % 9 == 8) ? 4'b1111 : ~(4'b0001 << o);
         chk("rr_gnt_n", gnt_n, exp_g);
         chk("rr_idx", gnt_idx, ((t - 1) % 9 == 8) ? 0 : o);
      end

      // Enable drop mid-grant, then search resumes after owner 2.
      reset_dut();
      drive(4'b1011, 1'b0, 1'b0);
      tick();
      chk("en_owner2", gnt_n, 4'b1011);
      drive(4'b1011, 1'b1, 1'b0);
      tick();
      chk("en_drop", gnt_n, 4'b1111);
      drive(4'b1010, 1'b0, 1'b0);
      tick();
      chk("en_wrap_gnt", gnt_n, 4'b1110);
      chk("en_wrap_idx", gnt_idx, 2'd0);

      // Reset mid-grant restores last=3.
      reset_dut();
      for (int n = 0; n < 5; n++) begin
         drive(4'b1101, 1'b0, 1'b0);
         tick();
      end
      chk("mid_owner1", gnt_n, 4'b1101);
      drive(4'b1001, 1'b0, 1'b1);
      tick();
      chk("mid_reset_gnt", gnt_n, 4'b1111);
      drive(4'b1001, 1'b0, 1'b0);
      tick();
      chk("mid_after_gnt", gnt_n, 4'b1101);
      chk("mid_after_idx", gnt_idx, 2'd1);

      // Randomized traffic with sticky requests, occasional enable drops and rare resets.
      r = 4'hf;
      e = 1'b0;
      for (int n = 0; n < 10000; n++) begin
         for (int b = 0; b < 4; b++)
            if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
         if ($urandom_range(0, 19) == 0) e = ~e;
         rs = ($urandom_range(0, 999) == 0);
         drive(r, e, rs);
         tick();
      end

      drive(4'hf, 1'b1, 1'b0);
      tick();
      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
